// File: rtl/parking_pkg.sv
// rtl/parking_pkg.sv - shared lane state encoding and category constants
package parking_pkg;

  typedef enum logic [2:0] {
    LANE_IDLE       = 3'd0,
    LANE_CHECK      = 3'd1,
    LANE_OPEN       = 3'd2,
    LANE_COMMIT     = 3'd3,
    LANE_WAIT_CLEAR = 3'd4
  } lane_state_t;

  localparam logic CAT_UNI  = 1'b1;
  localparam logic CAT_FREE = 1'b0;

endpackage

// File: rtl/gate_lane.sv
// rtl/gate_lane.sv - one barrier lane: FSM, category latch, optional timeout counter
// Optional feature macro: GATE_TIMEOUT_EN (open-gate timeout counter).
// Ports:
//   clock, reset           : clock, async active-high reset
//   req, is_uni            : car present at lane sensor and its category
//   passed                 : car cleared the barrier
//   uni_space, free_space  : space available per category (used in CHECK)
//   grant                  : the event pulse for this lane is on the bus this cycle
//   gate_open              : registered barrier actuator
//   category               : latched category of the car being served
//   commit_next            : lane will sit in COMMIT next cycle
//   deny_next              : lane is rejecting the request this cycle
//   timeout_next           : lane is abandoning an open gate this cycle
module gate_lane
  import parking_pkg::*;
#(
  parameter bit HAS_CHECK    = 1'b1,
  parameter int GATE_TIMEOUT = 500,
  parameter int TO_W         = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic req,
  input  logic is_uni,
  input  logic passed,
  input  logic uni_space,
  input  logic free_space,
  input  logic grant,
  output logic gate_open,
  output logic category,
  output logic commit_next,
  output logic deny_next,
  output logic timeout_next
);

  lane_state_t state, state_d;
  logic        expired;
  logic        has_space;

`ifdef GATE_TIMEOUT_EN
  logic [TO_W-1:0] count;

  // Held at zero outside OPEN, so it starts from zero on every OPEN entry;
  // saturates instead of wrapping.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (state != LANE_OPEN) begin
      count <= '0;
    end else if (count != '1) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (state == LANE_OPEN) && (count == TO_W'(GATE_TIMEOUT - 1));
`else
  logic unused_cfg;
  assign unused_cfg = (GATE_TIMEOUT > 0) ^ (TO_W > 0);
  assign expired    = 1'b0;
`endif

  assign has_space = (category == CAT_UNI) ? uni_space : free_space;

  // IDLE is always armed: it is only reached from reset or from WAIT_CLEAR
  // after the request has been seen low, so a held request never re-admits.
  always_comb begin
    state_d      = state;
    commit_next  = 1'b0;
    deny_next    = 1'b0;
    timeout_next = 1'b0;
    case (state)
      LANE_IDLE: begin
        if (req) begin
          if (HAS_CHECK) state_d = LANE_CHECK;
          else           state_d = LANE_OPEN;
        end
      end
      LANE_CHECK: begin
        if (has_space) begin
          state_d = LANE_OPEN;
        end else begin
          state_d   = LANE_WAIT_CLEAR;
          deny_next = 1'b1;
        end
      end
      LANE_OPEN: begin
        // A passage wins over an expiry in the same cycle.
        if (passed) begin
          state_d = LANE_COMMIT;
        end else if (expired) begin
          state_d      = LANE_WAIT_CLEAR;
          timeout_next = 1'b1;
        end
      end
      LANE_COMMIT: begin
        if (grant) state_d = LANE_WAIT_CLEAR;
      end
      LANE_WAIT_CLEAR: begin
        if (!req) state_d = LANE_IDLE;
      end
      default: state_d = LANE_IDLE;
    endcase
    commit_next = (state_d == LANE_COMMIT);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= LANE_IDLE;
      gate_open <= 1'b0;
      category  <= CAT_FREE;
    end else begin
      state     <= state_d;
      gate_open <= (state_d == LANE_OPEN);
      if (state == LANE_IDLE && req) category <= is_uni;
    end
  end

endmodule

// File: rtl/parking_gate_controller.sv
// rtl/parking_gate_controller.sv - entry/exit barrier controller producing Parking events
// Optional feature macro: GATE_TIMEOUT_EN (barrier closes after GATE_TIMEOUT open cycles).
// Ports:
//   clock, reset                       : clock, async active-high reset
//   arrive_req, arrive_is_uni          : entry sensor and category
//   depart_req, depart_is_uni          : exit sensor and category
//   passed_entry, passed_exit          : car cleared the barrier
//   uni/free_is_vacated_space          : space flags from Parking
//   faulty_exit                        : Parking flags the last exit as invalid
//   car_entered/is_uni_car_entered     : entry event pulse and qualifier
//   car_exited/is_uni_car_exited       : exit event pulse and qualifier
//   entry_gate_open, exit_gate_open    : barrier actuators
//   entry_denied, exit_fault,
//   gate_timeout                       : status pulses
module parking_gate_controller #(
  parameter int GATE_TIMEOUT = 500,
  parameter int TO_W         = 10
) (
  input  logic clock,
  input  logic reset,
  input  logic arrive_req,
  input  logic arrive_is_uni,
  input  logic depart_req,
  input  logic depart_is_uni,
  input  logic passed_entry,
  input  logic passed_exit,
  input  logic uni_is_vacated_space,
  input  logic free_is_vacated_space,
  input  logic faulty_exit,
  output logic car_entered,
  output logic is_uni_car_entered,
  output logic car_exited,
  output logic is_uni_car_exited,
  output logic entry_gate_open,
  output logic exit_gate_open,
  output logic entry_denied,
  output logic exit_fault,
  output logic gate_timeout
);

  logic entry_commit_next, entry_deny_next, entry_to_next, entry_cat;
  logic exit_commit_next, unused_exit_deny, exit_to_next, exit_cat;
  logic entry_fire;
  logic exited_d1;

  gate_lane #(
    .HAS_CHECK   (1'b1),
    .GATE_TIMEOUT(GATE_TIMEOUT),
    .TO_W        (TO_W)
  ) u_entry (
    .clock       (clock),
    .reset       (reset),
    .req         (arrive_req),
    .is_uni      (arrive_is_uni),
    .passed      (passed_entry),
    .uni_space   (uni_is_vacated_space),
    .free_space  (free_is_vacated_space),
    .grant       (car_entered),
    .gate_open   (entry_gate_open),
    .category    (entry_cat),
    .commit_next (entry_commit_next),
    .deny_next   (entry_deny_next),
    .timeout_next(entry_to_next)
  );

  // The exit lane always owns the event bus when it commits, so it never stalls.
  gate_lane #(
    .HAS_CHECK   (1'b0),
    .GATE_TIMEOUT(GATE_TIMEOUT),
    .TO_W        (TO_W)
  ) u_exit (
    .clock       (clock),
    .reset       (reset),
    .req         (depart_req),
    .is_uni      (depart_is_uni),
    .passed      (passed_exit),
    .uni_space   (1'b1),
    .free_space  (1'b1),
    .grant       (1'b1),
    .gate_open   (exit_gate_open),
    .category    (exit_cat),
    .commit_next (exit_commit_next),
    .deny_next   (unused_exit_deny),
    .timeout_next(exit_to_next)
  );

  // Entry yields to a same-cycle exit commit and fires one cycle later;
  // the exit lane cannot commit again that soon, so the stall is one cycle.
  assign entry_fire = entry_commit_next && !exit_commit_next;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      car_entered        <= 1'b0;
      is_uni_car_entered <= 1'b0;
      car_exited         <= 1'b0;
      is_uni_car_exited  <= 1'b0;
      entry_denied       <= 1'b0;
      gate_timeout       <= 1'b0;
      exit_fault         <= 1'b0;
      exited_d1          <= 1'b0;
    end else begin
      car_exited         <= exit_commit_next;
      is_uni_car_exited  <= exit_commit_next && exit_cat;
      car_entered        <= entry_fire;
      is_uni_car_entered <= entry_fire && entry_cat;
      entry_denied       <= entry_deny_next;
      gate_timeout       <= entry_to_next || exit_to_next;
      // Parking answers one cycle after our exit pulse.
      exited_d1          <= car_exited;
      exit_fault         <= exited_d1 && faulty_exit;
    end
  end

endmodule
